hex8_scan: RTL and testbench

Time-multiplexed scanner for the 8-digit common-anode seven-segment display. It takes a 32-bit hex value plus decimal-point and blanking masks, and cycles through the eight digits at a fixed refresh rate. Each step emits a 16-bit `{sel, seg}` pattern with a one-cycle valid strobe. It sits directly upstream of the 74HC595 serializer and drives that block's 16-bit parallel data input.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/hex_to_seg7.sv | 20 ++
 rtl/hex8_scan.sv | 91 +++++++++
 tb/tb_hex8_scan.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display blocks.
// The codes are active-low, bit order dp,g..a.
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [7:0]  SEG_OFF = 8'hFF;
   localparam logic [15:0] ALL_OFF = 16'hFFFF;

   localparam logic [7:0] SEG_TABLE [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0,
      8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83,
      8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low segment pattern, with dp and blanking.
// Blanking overrides dp.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_TABLE[nibble];
      if (dp)
         seg[7] = 1'b0;
      if (blank)
         seg = SEG_OFF;
   end

endmodule

// File: rtl/hex8_scan.sv
// 8-digit multiplexed seven-segment scanner.
// Emits registered {sel, seg} words with a one-cycle valid strobe.
module hex8_scan
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] disp_data,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  blank_mask,
   output logic [15:0] data_out,
   output logic        data_vld
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [CW-1:0] cnt;
   logic [IW-1:0] nxt;
   logic          en_q;
   logic [31:0]   sh_data;
   logic [7:0]    sh_dp;
   logic [7:0]    sh_blank;

   logic          tick;
   logic          frame_start;
   logic [31:0]   cur_data;
   logic [7:0]    cur_dp;
   logic [7:0]    cur_blank;
   logic [3:0]    nib;
   logic [7:0]    seg;
   logic [7:0]    sel;

   assign tick        = en && (cnt == CW'(SCAN_DIV - 1));
   assign frame_start = (nxt == '0);

   // Digit 0 reads live inputs; the rest of the frame reads the snapshot.
   assign cur_data  = frame_start ? disp_data  : sh_data;
   assign cur_dp    = frame_start ? dp_mask    : sh_dp;
   assign cur_blank = frame_start ? blank_mask : sh_blank;

   assign nib = cur_data[{nxt, 2'b00} +: 4];
   assign sel = ~(8'h01 << nxt);

   hex_to_seg7 u_dec (
      .nibble (nib),
      .dp     (cur_dp[nxt]),
      .blank  (cur_blank[nxt]),
      .seg    (seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         nxt      <= '0;
         en_q     <= 1'b0;
         sh_data  <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
         data_out <= ALL_OFF;
         data_vld <= 1'b0;
      end else begin
         en_q     <= en;
         data_vld <= 1'b0;
         if (!en) begin
            cnt <= '0;
            nxt <= '0;
            if (en_q) begin
               data_out <= ALL_OFF;
               data_vld <= 1'b1;
            end
         end else if (tick) begin
            cnt      <= '0;
            nxt      <= nxt + IW'(1);
            data_out <= {sel, seg};
            data_vld <= 1'b1;
            if (frame_start) begin
               sh_data  <= disp_data;
               sh_dp    <= dp_mask;
               sh_blank <= blank_mask;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_hex8_scan.sv
// Directed bench for hex8_scan with SCAN_DIV=4.
// Expected words are hand-computed from the segment table.
module tb_hex8_scan;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] disp_data;
   logic [7:0]  dp_mask;
   logic [7:0]  blank_mask;
   logic [15:0] data_out;
   logic        data_vld;

   int passed = 0;
   int total  = 0;

   hex8_scan #(.SCAN_DIV(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .disp_data  (disp_data),
      .dp_mask    (dp_mask),
      .blank_mask (blank_mask),
      .data_out   (data_out),
      .data_vld   (data_vld)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // SD-1 quiet edges, then a pulse carrying exp.
   task automatic wait_digit(input string tag, input logic [15:0] exp);
      int spur = 0;
      for (int i = 0; i < SD - 1; i++) begin
         step();
         if (data_vld !== 1'b0)
            spur++;
      end
      chk({tag, "_gap"}, spur, 0);
      step();
      chk(tag, {data_vld, data_out}, {1'b1, exp});
   endtask

   task automatic quiet(input string tag, input int n);
      int spur = 0;
      int bad  = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (data_vld !== 1'b0)
            spur++;
         if (data_out !== 16'hFFFF)
            bad++;
      end
      chk(tag, {spur[15:0], bad[15:0]}, 32'h0);
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b1;
      disp_data  = 32'h7654_3210;
      dp_mask    = 8'h00;
      blank_mask = 8'h00;

      // Scenario 1: reset then a full scan plus wrap
      step();
      step();
      chk("rst_out", {data_vld, data_out}, {1'b0, 16'hFFFF});
      rst = 1'b0;
      wait_digit("s1_d0", 16'hFEC0);
      wait_digit("s1_d1", 16'hFDF9);
      wait_digit("s1_d2", 16'hFBA4);
      wait_digit("s1_d3", 16'hF7B0);
      wait_digit("s1_d4", 16'hEF99);
      wait_digit("s1_d5", 16'hDF92);
      wait_digit("s1_d6", 16'hBF82);
      wait_digit("s1_d7", 16'h7FF8);
      wait_digit("s1_wrap", 16'hFEC0);
      wait_digit("s1_f2d1", 16'hFDF9);
      wait_digit("s1_f2d2", 16'hFBA4);
      wait_digit("s1_f2d3", 16'hF7B0);
      wait_digit("s1_f2d4", 16'hEF99);
      wait_digit("s1_f2d5", 16'hDF92);
      wait_digit("s1_f2d6", 16'hBF82);
      wait_digit("s1_f2d7", 16'h7FF8);

      // Scenario 2: hex letters
      disp_data = 32'hFEDC_BA98;
      wait_digit("s2_d0", 16'hFE80);
      wait_digit("s2_d1", 16'hFD90);
      wait_digit("s2_d2", 16'hFB88);
      wait_digit("s2_d3", 16'hF783);
      wait_digit("s2_d4", 16'hEFC6);
      wait_digit("s2_d5", 16'hDFA1);
      wait_digit("s2_d6", 16'hBF86);
      wait_digit("s2_d7", 16'h7F8E);

      // Scenario 3: dp and blanking
      disp_data  = 32'h0;
      dp_mask    = 8'h01;
      blank_mask = 8'h03;
      wait_digit("s3_d0", 16'hFEFF);
      wait_digit("s3_d1", 16'hFDFF);
      wait_digit("s3_d2", 16'hFBC0);
      wait_digit("s3_d3", 16'hF7C0);

      // Scenario 4: mid-frame change must not tear
      disp_data  = 32'h1111_1111;
      dp_mask    = 8'h00;
      blank_mask = 8'h00;
      wait_digit("s4_d4", 16'hEFC0);
      wait_digit("s4_d5", 16'hDFC0);
      wait_digit("s4_d6", 16'hBFC0);
      wait_digit("s4_d7", 16'h7FC0);
      wait_digit("s4_d0", 16'hFEF9);
      wait_digit("s4_d1", 16'hFDF9);
      wait_digit("s4_d2", 16'hFBF9);
      wait_digit("s4_d3", 16'hF7F9);

      // Scenario 5: disable while digit 3 shown
      en = 1'b0;
      step();
      chk("s5_off", {data_vld, data_out}, {1'b1, 16'hFFFF});
      quiet("s5_hold", 10);
      en = 1'b1;
      wait_digit("s5_re_d0", 16'hFEF9);
      wait_digit("s5_re_d1", 16'hFDF9);

      // Scenario 6a: reset mid-frame
      step();
      rst = 1'b1;
      step();
      chk("s6_rst", {data_vld, data_out}, {1'b0, 16'hFFFF});
      rst = 1'b0;
      wait_digit("s6_rs_d0", 16'hFEF9);

      // Scenario 6b: en falls on the tick edge
      step();
      step();
      step();
      en = 1'b0;
      step();
      chk("s6_tick_off", {data_vld, data_out}, {1'b1, 16'hFFFF});
      quiet("s6_hold", 6);
      disp_data = 32'h2222_2222;
      en = 1'b1;
      wait_digit("s6_re_d0", 16'hFEA4);
      wait_digit("s6_re_d1", 16'hFDA4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
